ahb_sram_bridge: RTL and testbench

- AHB-Lite slave that terminates the bus driven by the BIU's bus arbiter (haddr/hwrite/hsize/htrans/hwdata out, hready/hresp/hrdata back) onto a single-port synchronous 64-bit on-chip SRAM.
- Serves L1-I line refills, L1-D line refills/writebacks, write-through and uncached accesses, and external bus-master traffic.
- Pipelined address/data phases, per-byte write enables, two-cycle ERROR response for illegal accesses.

---
 rtl/ahb_pkg.sv | 38 +++
 rtl/ahb_sram_bridge_wbuf.sv | 79 +++++++
 rtl/ahb_sram_bridge.sv | 202 ++++++++++++++++++++
 tb/tb_ahb_sram_bridge.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, bridge state encoding and the size/lane to byte-enable helper.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_B = 3'd0;
  localparam logic [2:0] HSIZE_H = 3'd1;
  localparam logic [2:0] HSIZE_W = 3'd2;
  localparam logic [2:0] HSIZE_D = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_RDW  = 3'd3,
    ST_ERR1 = 3'd4,
    ST_ERR2 = 3'd5
  } ahb_state_e;

  function automatic logic [7:0] ahb_size_to_be(input logic [2:0] size, input logic [2:0] addr_lo);
    logic [7:0] be;
    case (size)
      HSIZE_B: be = 8'h01 << addr_lo;
      HSIZE_H: be = 8'h03 << addr_lo;
      HSIZE_W: be = 8'h0F << addr_lo;
      HSIZE_D: be = 8'hFF;
      default: be = 8'h00;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_bridge_wbuf.sv
// One-entry posted-write buffer: holds a write displaced by a read, forwards its bytes to a matching read.
module ahb_sram_wbuf
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              hreset_n,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  input  logic [7:0]        load_be_i,
  input  logic [63:0]       load_data_i,
  input  logic              drain_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [63:0]       sram_rdata_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        be_o,
  output logic [63:0]       data_o,
  output logic [63:0]       rdata_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        be_q, be_d;
  logic [63:0]       data_q, data_d;
  logic              hit_s;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    be_d    = be_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = load_addr_i;
      be_d    = load_be_i;
      data_d  = load_data_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge hreset_n) begin
    if (!hreset_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      be_q    <= 8'h00;
      data_q  <= 64'd0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      data_q  <= data_d;
    end
  end

  assign hit_s = valid_q && (addr_q == rd_addr_i);

  // Buffered bytes are newer than the SRAM copy of the same dword
  always_comb begin
    rdata_o = sram_rdata_i;
    for (int i = 0; i < 8; i++) begin
      if (hit_s && be_q[i]) begin
        rdata_o[i*8 +: 8] = data_q[i*8 +: 8];
      end else begin
        rdata_o[i*8 +: 8] = sram_rdata_i[i*8 +: 8];
      end
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign be_o    = be_q;
  assign data_o  = data_q;

endmodule

// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave bridging onto a single-port 64-bit synchronous SRAM.
// Define AHB_SRAM_WBUF_EN to replace the read-after-write wait state with a one-entry write buffer.
module ahb_sram_bridge
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 14,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
  input  logic              clk,
  input  logic              hreset_n,
  input  logic              hsel,
  input  logic [63:0]       haddr,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [1:0]        htrans,
  input  logic [63:0]       hwdata,
  input  logic              hready_in,
  output logic              hreadyout,
  output logic              hresp,
  output logic [63:0]       hrdata,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [7:0]        sram_be,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [63:0]       sram_wdata,
  input  logic [63:0]       sram_rdata
);

  localparam logic [63:0] WIN_BYTES = 64'd8 << ADDR_W;

  ahb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        wr_be_q, wr_be_d;

  logic [63:0]       offset_s;
  logic [ADDR_W-1:0] ap_addr_s;
  logic [7:0]        ap_be_s;
  logic              aligned_s;
  logic              legal_s;
  logic              accept_s;
  logic              rd_issue_s;
  logic              in_wr_s;
  logic [63:0]       rd_data_s;
  logic              unused_s;

  assign offset_s  = haddr - BASE_ADDR;
  assign ap_addr_s = offset_s[ADDR_W+2:3];
  assign ap_be_s   = ahb_size_to_be(hsize, haddr[2:0]);
  assign in_wr_s   = (state_q == ST_WR);
  assign unused_s  = ^hburst;

  assign hreadyout = (state_q != ST_RDW) && (state_q != ST_ERR1);
  assign hresp     = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  assign accept_s  = hsel && hready_in && hreadyout &&
                     ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  always_comb begin
    case (hsize)
      HSIZE_B: aligned_s = 1'b1;
      HSIZE_H: aligned_s = (haddr[0] == 1'b0);
      HSIZE_W: aligned_s = (haddr[1:0] == 2'b00);
      HSIZE_D: aligned_s = (haddr[2:0] == 3'b000);
      default: aligned_s = 1'b0;
    endcase
  end

  // Below-base addresses wrap to a huge offset and fail the window check too
  assign legal_s = aligned_s && (offset_s < WIN_BYTES);

`ifdef AHB_SRAM_WBUF_EN
  assign rd_issue_s = hreset_n && accept_s && legal_s && !hwrite;
`else
  assign rd_issue_s = hreset_n && accept_s && legal_s && !hwrite && !in_wr_s;
`endif

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_be_d   = wr_be_q;
    rd_addr_d = rd_addr_q;
    case (state_q)
      ST_RDW:  state_d = ST_RD;
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        if (!accept_s) begin
          state_d = ST_IDLE;
        end else if (!legal_s) begin
          state_d = ST_ERR1;
        end else if (hwrite) begin
          state_d   = ST_WR;
          wr_addr_d = ap_addr_s;
          wr_be_d   = ap_be_s;
        end else begin
          rd_addr_d = ap_addr_s;
`ifdef AHB_SRAM_WBUF_EN
          state_d   = ST_RD;
`else
          state_d   = in_wr_s ? ST_RDW : ST_RD;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q   <= ST_IDLE;
      wr_addr_q <= '0;
      wr_be_q   <= 8'h00;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_be_q   <= wr_be_d;
      rd_addr_q <= rd_addr_d;
    end
  end

`ifdef AHB_SRAM_WBUF_EN
  logic              buf_valid_s;
  logic [ADDR_W-1:0] buf_addr_s;
  logic [7:0]        buf_be_s;
  logic [63:0]       buf_data_s;
  logic              buf_load_s;
  logic              buf_drain_s;

  // The buffer drains in the write's own address phase, so it is always empty on entry to WR
  assign buf_load_s  = in_wr_s && rd_issue_s;
  assign buf_drain_s = buf_valid_s && !rd_issue_s && !in_wr_s;

  ahb_sram_wbuf #(.ADDR_W(ADDR_W)) u_wbuf (
    .clk          (clk),
    .hreset_n     (hreset_n),
    .load_i       (buf_load_s),
    .load_addr_i  (wr_addr_q),
    .load_be_i    (wr_be_q),
    .load_data_i  (hwdata),
    .drain_i      (buf_drain_s),
    .rd_addr_i    (rd_addr_q),
    .sram_rdata_i (sram_rdata),
    .valid_o      (buf_valid_s),
    .addr_o       (buf_addr_s),
    .be_o         (buf_be_s),
    .data_o       (buf_data_s),
    .rdata_o      (rd_data_s)
  );

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 8'h00;
    sram_addr  = '0;
    sram_wdata = hwdata;
    if (rd_issue_s) begin
      sram_ce   = 1'b1;
      sram_addr = ap_addr_s;
    end else if (in_wr_s) begin
      sram_ce   = 1'b1;
      sram_we   = 1'b1;
      sram_be   = wr_be_q;
      sram_addr = wr_addr_q;
    end else if (buf_drain_s) begin
      sram_ce    = 1'b1;
      sram_we    = 1'b1;
      sram_be    = buf_be_s;
      sram_addr  = buf_addr_s;
      sram_wdata = buf_data_s;
    end else begin
      sram_ce = 1'b0;
    end
  end
`else
  assign rd_data_s = sram_rdata;

  always_comb begin
    sram_ce    = 1'b0;
    sram_we    = 1'b0;
    sram_be    = 8'h00;
    sram_addr  = '0;
    sram_wdata = hwdata;
    if (in_wr_s) begin
      sram_ce   = 1'b1;
      sram_we   = 1'b1;
      sram_be   = wr_be_q;
      sram_addr = wr_addr_q;
    end else if (state_q == ST_RDW) begin
      sram_ce   = 1'b1;
      sram_addr = rd_addr_q;
    end else if (rd_issue_s) begin
      sram_ce   = 1'b1;
      sram_addr = ap_addr_s;
    end else begin
      sram_ce = 1'b0;
    end
  end
`endif

  assign hrdata = (state_q == ST_RD) ? rd_data_s : 64'd0;

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Directed, scoreboard-checked bench for ahb_sram_bridge with a behavioural synchronous SRAM.
module tb_ahb_sram_bridge;
  import ahb_pkg::*;

  localparam int unsigned ADDR_W = 14;
  localparam logic [63:0] BASE   = 64'h0000_0000_8000_0000;

  logic              clk = 1'b0;
  logic              hreset_n;
  logic              hsel;
  logic [63:0]       haddr;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [1:0]        htrans;
  logic [63:0]       hwdata;
  logic              hready_in;
  logic              hreadyout;
  logic              hresp;
  logic [63:0]       hrdata;
  logic              sram_ce;
  logic              sram_we;
  logic [7:0]        sram_be;
  logic [ADDR_W-1:0] sram_addr;
  logic [63:0]       sram_wdata;
  logic [63:0]       sram_rdata = 64'd0;

  always #5 clk = ~clk;
  assign hready_in = hreadyout;

  ahb_sram_bridge #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .hreset_n   (hreset_n),
    .hsel       (hsel),
    .haddr      (haddr),
    .hwrite     (hwrite),
    .hsize      (hsize),
    .hburst     (hburst),
    .htrans     (htrans),
    .hwdata     (hwdata),
    .hready_in  (hready_in),
    .hreadyout  (hreadyout),
    .hresp      (hresp),
    .hrdata     (hrdata),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  bit [63:0] mem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (sram_ce && sram_we) begin
      for (int i = 0; i < 8; i++) begin
        if (sram_be[i]) mem[sram_addr][i*8 +: 8] <= sram_wdata[i*8 +: 8];
      end
    end
    if (sram_ce && !sram_we) sram_rdata <= mem[sram_addr];
  end

  int                ce_count = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [7:0]        last_wr_be = 8'h00;
  logic [ADDR_W-1:0] rd_log [$];

  always @(negedge clk) begin
    if (sram_ce) begin
      ce_count <= ce_count + 1;
      if (sram_we) begin
        last_wr_addr <= sram_addr;
        last_wr_be   <= sram_be;
      end else begin
        rd_log.push_back(sram_addr);
      end
    end
  end

  typedef enum int {DP_NONE, DP_RD, DP_WR, DP_ERR} dp_e;
  dp_e         dp_kind = DP_NONE;
  logic [63:0] exp_q [$];
  logic [63:0] shadow [int];
  int          n_cmp = 0;
  int          n_err = 0;
  int          waits = 0;
  int          max_waits = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic bit legal_m(input logic [2:0] size, input logic [63:0] addr);
    logic [63:0] off;
    off = addr - BASE;
    if (size > 3'd3) return 1'b0;
    if (off >= (64'd8 << ADDR_W)) return 1'b0;
    return (addr % (64'd1 << size)) == 64'd0;
  endfunction

  function automatic logic [7:0] be_m(input logic [2:0] size, input logic [63:0] addr);
    logic [7:0] m;
    int n;
    m = 8'h00;
    n = 1 << size;
    for (int i = 0; i < n; i++) m[int'(addr[2:0]) + i] = 1'b1;
    return m;
  endfunction

  function automatic int dw(input logic [63:0] addr);
    return int'((addr - BASE) >> 3);
  endfunction

  function automatic logic [63:0] sh_read(input logic [63:0] addr);
    return shadow.exists(dw(addr)) ? shadow[dw(addr)] : 64'd0;
  endfunction

  task automatic sh_write(input logic [63:0] addr, input logic [2:0] size, input logic [63:0] data);
    logic [63:0] cur;
    logic [7:0]  m;
    cur = sh_read(addr);
    m   = be_m(size, addr);
    for (int i = 0; i < 8; i++) if (m[i]) cur[i*8 +: 8] = data[i*8 +: 8];
    shadow[dw(addr)] = cur;
  endtask

  // One address phase; completes the pending data phase and checks it
  task automatic bus(input logic sel, input logic [1:0] trans, input logic wr, input logic [2:0] size,
                     input logic [63:0] addr, input logic [63:0] wdata);
    int guard;
    hsel = sel; htrans = trans; hwrite = wr; hsize = size; haddr = addr;
    guard = 0;
    waits = 0;
    @(negedge clk);
    while (hreadyout !== 1'b1 && guard < 8) begin
      if (dp_kind == DP_ERR) chk("err1_resp", hresp, 64'd1);
      waits++;
      guard++;
      @(negedge clk);
    end
    if (guard >= 8) begin
      chk("hready_timeout", hreadyout, 64'd1);
    end else begin
      case (dp_kind)
        DP_RD: begin
          chk("rd_resp", hresp, 64'd0);
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL rd_scoreboard: observed=%h expected=<none queued>", hrdata);
          end else begin
            chk("rd_data", hrdata, exp_q.pop_front());
          end
        end
        DP_ERR: begin
          chk("err2_resp", hresp, 64'd1);
          chk("err_waits", 64'(waits), 64'd1);
        end
        default: chk("okay_resp", hresp, 64'd0);
      endcase
    end
    if (waits > max_waits) max_waits = waits;
    @(posedge clk);
    #1;
    if (sel && trans[1]) begin
      if (!legal_m(size, addr)) begin
        dp_kind = DP_ERR;
      end else if (wr) begin
        dp_kind = DP_WR;
        hwdata  = wdata;
        sh_write(addr, size, wdata);
      end else begin
        dp_kind = DP_RD;
        exp_q.push_back(sh_read(addr));
      end
    end else begin
      dp_kind = DP_NONE;
    end
  endtask

  task automatic idle();
    bus(1'b0, HTRANS_IDLE, 1'b0, HSIZE_D, 64'd0, 64'd0);
  endtask

  initial begin
    int ce0;
    int rd0;
    logic [63:0] old_v;

    hreset_n = 1'b0; hsel = 1'b0; haddr = 64'd0; hwrite = 1'b0; hsize = 3'd0;
    hburst = 3'd0; htrans = HTRANS_IDLE; hwdata = 64'd0;

    // Reset state
    @(negedge clk);
    chk("rst_hreadyout", hreadyout, 64'd1);
    chk("rst_hresp", hresp, 64'd0);
    chk("rst_sram_ce", sram_ce, 64'd0);
    chk("rst_sram_we", sram_we, 64'd0);
    chk("rst_sram_be", sram_be, 64'd0);
    chk("rst_hrdata", hrdata, 64'd0);
    @(posedge clk);
    #1;
    hreset_n = 1'b1;
    idle();
    idle();
    chk("idle_ce", 64'(ce_count), 64'd0);

    // Byte write over zero contents, then dword read
    bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_B, BASE + 64'h13, 64'hAB << 24);
    bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_D, BASE + 64'h10, 64'd0);
    idle();
    idle();
    chk("byte_be", last_wr_be, 64'h08);
    chk("byte_addr", last_wr_addr, 64'd2);
    chk("byte_exp", sh_read(BASE + 64'h10), 64'h0000_0000_AB00_0000);

    // Dword write and immediate read of the same address
    bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_D, BASE + 64'h10, 64'h1122334455667788);
    bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_D, BASE + 64'h10, 64'd0);
    idle();
`ifdef AHB_SRAM_WBUF_EN
    chk("raw_waits", 64'(waits), 64'd0);
`else
    chk("raw_waits", 64'(waits), 64'd1);
`endif
    idle();
    chk("dword_be", last_wr_be, 64'hFF);
    chk("dword_addr", last_wr_addr, 64'd2);

    // Half and word lanes
    bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_H, BASE + 64'h26, 64'hBEEF_0000_0000_0000);
    idle();
    chk("half_be", last_wr_be, 64'hC0);
    bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_W, BASE + 64'h2C, 64'hDEAD_BEEF_0000_0000);
    bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_D, BASE + 64'h20, 64'd0);
    bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_D, BASE + 64'h28, 64'd0);
    idle();
    idle();
    chk("word_be", last_wr_be, 64'hF0);

    // Fill 0x40..0x78 with a write burst, then INCR8 read burst
    max_waits = 0;
    hburst = 3'b101;
    for (int k = 0; k < 8; k++) begin
      bus(1'b1, (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b1, HSIZE_D, BASE + 64'h40 + 64'(8*k),
          64'hA5A5_0000_0000_0000 + 64'(k * 64'h0101_0101));
    end
    hburst = 3'b000;
    idle();
    idle();
    chk("wr_burst_waits", 64'(max_waits), 64'd0);
    max_waits = 0;
    rd0 = rd_log.size();
    hburst = 3'b101;
    for (int k = 0; k < 8; k++) begin
      bus(1'b1, (k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 1'b0, HSIZE_D, BASE + 64'h40 + 64'(8*k), 64'd0);
    end
    hburst = 3'b000;
    idle();
    chk("rd_burst_waits", 64'(max_waits), 64'd0);
    chk("rd_burst_count", 64'(rd_log.size() - rd0), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (rd0 + k < rd_log.size()) chk("rd_burst_addr", rd_log[rd0 + k], 64'(8 + k));
    end

    // Illegal accesses: ERR1/ERR2 and no SRAM activity
    ce0 = ce_count;
    bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_D, BASE + (64'd8 << ADDR_W), 64'd0);
    idle();
    chk("ill_range_ce", 64'(ce_count - ce0), 64'd0);
    ce0 = ce_count;
    bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_W, BASE + 64'h2, 64'hFFFF_FFFF);
    idle();
    chk("ill_align_ce", 64'(ce_count - ce0), 64'd0);
    ce0 = ce_count;
    bus(1'b1, HTRANS_NONSEQ, 1'b0, 3'd5, BASE + 64'h8, 64'd0);
    idle();
    chk("ill_size_ce", 64'(ce_count - ce0), 64'd0);
    chk("post_err_resp", hresp, 64'd0);

    // Reset asserted during the WR beat of a write burst
    bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_D, BASE + 64'h100, 64'h0123_4567_89AB_CDEF);
    idle();
    idle();
    old_v = sh_read(BASE + 64'h100);
    bus(1'b1, HTRANS_NONSEQ, 1'b1, HSIZE_D, BASE + 64'h100, 64'hFEED_FACE_0BAD_F00D);
    hsel = 1'b1; htrans = HTRANS_SEQ; hwrite = 1'b1; haddr = BASE + 64'h108;
    hreset_n = 1'b0;
    #1;
    chk("midrst_we", sram_we, 64'd0);
    chk("midrst_ce", sram_ce, 64'd0);
    chk("midrst_hreadyout", hreadyout, 64'd1);
    chk("midrst_hresp", hresp, 64'd0);
    @(posedge clk);
    #1;
    hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    @(posedge clk);
    #1;
    hreset_n = 1'b1;
    dp_kind = DP_NONE;
    shadow[dw(BASE + 64'h100)] = old_v;
    bus(1'b1, HTRANS_NONSEQ, 1'b0, HSIZE_D, BASE + 64'h100, 64'd0);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
